ic_mem_resp: RTL and testbench
==============================

// Module: ic_mem_resp
// PURPOSE
//  DRAM-side responder for the icache line-fill interface. Queues icache line
//  read requests (addr[26:4] + 2-bit xid), issues one 4-beat 32-bit burst per
//  line to the DRAM backend, assembles each 128-bit line and returns it with
//  its xid as a single-cycle mem_ic_valid pulse. Requests are served in order.
// PARAMETERS
//  REQ_DEPTH     4  request FIFO entries (power of 2, >=2)
//  LG_REQ_DEPTH  2  log2(REQ_DEPTH)
// PORTS
//  clk           in   1    clock
//  rst           in   1    synchronous reset, active-high
//  ic_mem_addr   in   23   [26:4] line address of request
//  ic_mem_xid    in   2    transaction id from icache
//  ic_mem_re     in   1    request valid
//  mem_ic_ready  out  1    request FIFO can accept (= !full)
//  mem_ic_valid  out  1    line return pulse, one cycle, no backpressure
//  mem_ic_xid    out  2    xid of returned line
//  mem_ic_data   out  128  returned line; word i at [i*32+:32]
//  dram_req      out  1    burst request valid
//  dram_addr     out  23   [26:4] burst line address
//  dram_gnt      in   1    backend accepts burst (same cycle as dram_req)
//  dram_rvalid   in   1    read beat valid
//  dram_rdata    in   32   read beat data, ascending word order
//  resp_err      out  1    sticky: beat received outside DATA state
// BEHAVIOUR
//  Reset values: mem_ic_ready=1 after reset cycle (0 while rst=1),
//   mem_ic_valid=0, mem_ic_xid=0, mem_ic_data=0, dram_req=0, dram_addr=0,
//   resp_err=0; FIFO empty, FSM=IDLE, beat count=0.
//  Request accept: push {addr,xid} when ic_mem_re & mem_ic_ready. ic_mem_re
//   with mem_ic_ready=0 is dropped (icache retries). Full = REQ_DEPTH entries;
//   a same-cycle pop does NOT free a slot for that cycle's push.
//  FSM (registered state; outputs decoded from state/registers):
//   IDLE: FIFO non-empty -> REQ next cycle.
//   REQ:  dram_req=1, dram_addr=FIFO head addr. dram_gnt -> pop head, latch
//         xid, clear beat count, -> DATA. Otherwise hold request stable.
//   DATA: each dram_rvalid writes dram_rdata to line word[beat], beat++
//         (2-bit, wraps). Beat 3 -> RESP. Gaps between beats allowed.
//   RESP: mem_ic_valid=1 exactly one cycle with latched xid and full line;
//         -> REQ if FIFO non-empty, else IDLE.
//  mem_ic_data/xid held stable outside RESP until next RESP overwrites.
//  Latency: push at cycle T (FIFO was empty, FSM IDLE) -> dram_req at T+2;
//   gnt at G -> beats from G+1; last beat at L -> mem_ic_valid at L+1.
//  Back-to-back: RESP->REQ gives one dead cycle; consecutive mem_ic_valid
//   pulses are >=3 cycles apart; icache tolerates any spacing.
//  dram_rvalid in IDLE/REQ/RESP: beat ignored, resp_err<=1 (sticky until rst).
//  Duplicate xids / addresses not checked; serviced in arrival order.
//  Reset mid-operation: FIFO flushed, partial line discarded, no mem_ic_valid.
//   Backend is reset by the same rst; no stale beats arrive afterwards.
// TESTING
//  1. Push addr=0x000123 xid=2 into idle block; gnt same cycle as dram_req;
//     beats 0x11111111,0x22222222,0x33333333,0x44444444 -> one mem_ic_valid,
//     xid=2, data=0x44444444_33333333_22222222_11111111, dram_addr=0x000123.
//  2. Push 5 requests back-to-back, dram_gnt=0 -> mem_ic_ready low after 4th
//     push, 5th dropped; release gnt -> 4 responses in order, xids match.
//  3. dram_gnt held low 10 cycles -> dram_req/dram_addr stable throughout,
//     no FIFO pop, no beats accepted as data.
//  4. Beats with 3-cycle gaps -> correct word placement, valid 1 cycle after
//     beat 3, beat counter restarts at 0 for the next request.
//  5. rst=1 after beat 1 of a burst -> no mem_ic_valid, ready=1 and all
//     outputs at reset values the cycle after rst drops; new request works.
//  6. dram_rvalid pulse in IDLE -> resp_err=1, stays 1 across later traffic,
//     no mem_ic_valid produced; cleared only by rst.

Source files
------------

// File: rtl/ic_mem_resp.sv
// ---------------------------------------------------------------------------
// ic_mem_resp
//
// DRAM-side responder for the icache line-fill interface. Line read requests
// from the icache are queued in a small FIFO and served strictly in order:
// one 4-beat 32-bit burst is requested from the DRAM backend per line, the
// beats are assembled into a 128-bit line, and the line is returned together
// with its xid as a single-cycle mem_ic_valid pulse.
//
// Ports
//   clk           in   1    clock
//   rst           in   1    synchronous reset, active-high
//   ic_mem_addr   in   23   line address [26:4] of the request
//   ic_mem_xid    in   2    icache transaction id
//   ic_mem_re     in   1    request valid
//   mem_ic_ready  out  1    request FIFO can accept (low when full or in reset)
//   mem_ic_valid  out  1    line return pulse, one cycle, no backpressure
//   mem_ic_xid    out  2    xid of the returned line
//   mem_ic_data   out  128  returned line, word i at [i*32 +: 32]
//   dram_req      out  1    burst request valid
//   dram_addr     out  23   burst line address [26:4]
//   dram_gnt      in   1    backend accepts the burst this cycle
//   dram_rvalid   in   1    read beat valid
//   dram_rdata    in   32   read beat data, ascending word order
//   resp_err      out  1    sticky: a beat arrived outside the DATA state
// ---------------------------------------------------------------------------
module ic_mem_resp #(
    parameter int REQ_DEPTH    = 4,
    parameter int LG_REQ_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [22:0]   ic_mem_addr,
    input  logic [1:0]    ic_mem_xid,
    input  logic          ic_mem_re,
    output logic          mem_ic_ready,
    output logic          mem_ic_valid,
    output logic [1:0]    mem_ic_xid,
    output logic [127:0]  mem_ic_data,
    output logic          dram_req,
    output logic [22:0]   dram_addr,
    input  logic          dram_gnt,
    input  logic          dram_rvalid,
    input  logic [31:0]   dram_rdata,
    output logic          resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [LG_REQ_DEPTH:0]   FULL_CNT = (LG_REQ_DEPTH + 1)'(REQ_DEPTH);
    localparam logic [LG_REQ_DEPTH:0]   CNT_ONE  = (LG_REQ_DEPTH + 1)'(1);
    localparam logic [LG_REQ_DEPTH-1:0] PTR_ONE  = LG_REQ_DEPTH'(1);

    state_t state_q, state_d;

    // Request FIFO
    logic [22:0]             fifo_addr [REQ_DEPTH];
    logic [1:0]              fifo_xid  [REQ_DEPTH];
    logic [LG_REQ_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [LG_REQ_DEPTH:0]   count;
    logic                    full, empty, push, pop;

    // Line assembly and returned-line registers
    logic [1:0]        beat_q;
    logic [1:0]        xid_q;
    logic [2:0][31:0]  line_buf;     // words 0..2; word 3 goes straight to the output
    logic [1:0]        out_xid;
    logic [127:0]      out_data;
    logic              beat_in_data;
    logic              last_beat;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Full is judged on the registered count, so a pop in the same cycle
    // never makes room for that cycle's push.
    assign mem_ic_ready = ~rst & ~full;
    assign push         = ic_mem_re & mem_ic_ready;
    assign pop          = (state_q == REQ) & dram_gnt;

    assign beat_in_data = (state_q == DATA) & dram_rvalid;
    assign last_beat    = beat_in_data & (beat_q == 2'd3);

    // NOTE: FIFO storage and the line buffer are datapath only; valid data is
    // tracked by count/state, so they carry no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ic_mem_addr;
            fifo_xid[wr_ptr]  <= ic_mem_xid;
        end
        if (beat_in_data) begin
            case (beat_q)
                2'd0:    line_buf[0] <= dram_rdata;
                2'd1:    line_buf[1] <= dram_rdata;
                2'd2:    line_buf[2] <= dram_rdata;
                default: ;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_q   <= '0;
            xid_q    <= '0;
            out_xid  <= '0;
            out_data <= '0;
            resp_err <= 1'b0;
        end else begin
            state_q <= state_d;

            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase

            if (pop) begin
                xid_q  <= fifo_xid[rd_ptr];
                beat_q <= '0;
            end else if (beat_in_data) begin
                beat_q <= beat_q + 2'd1;
            end

            // The returned line is loaded in one shot on the last beat, so
            // mem_ic_data/xid stay stable while the next line is assembled.
            if (last_beat) begin
                out_data <= {dram_rdata, line_buf};
                out_xid  <= xid_q;
            end

            if (dram_rvalid && (state_q != DATA)) resp_err <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        dram_req     = 1'b0;
        dram_addr    = '0;
        mem_ic_valid = 1'b0;
        mem_ic_xid   = out_xid;
        mem_ic_data  = out_data;

        case (state_q)
            IDLE: begin
                if (!empty) state_d = REQ;
            end
            REQ: begin
                dram_req  = 1'b1;
                dram_addr = fifo_addr[rd_ptr];
                if (dram_gnt) state_d = DATA;
            end
            DATA: begin
                if (last_beat) state_d = RESP;
            end
            RESP: begin
                mem_ic_valid = 1'b1;
                state_d      = empty ? IDLE : REQ;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ic_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_ic_mem_resp
//
// Directed bench for ic_mem_resp. A table of single-line transactions (with
// hand-computed expected lines) is applied in a loop; hand-written sequences
// cover FIFO full/drop, reset in mid-burst and the sticky error flag.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ic_mem_resp;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [22:0]   ic_mem_addr = '0;
    logic [1:0]    ic_mem_xid = '0;
    logic          ic_mem_re = 1'b0;
    logic          mem_ic_ready;
    logic          mem_ic_valid;
    logic [1:0]    mem_ic_xid;
    logic [127:0]  mem_ic_data;
    logic          dram_req;
    logic [22:0]   dram_addr;
    logic          dram_gnt = 1'b0;
    logic          dram_rvalid = 1'b0;
    logic [31:0]   dram_rdata = '0;
    logic          resp_err;

    always #5 clk = ~clk;

    ic_mem_resp #(.REQ_DEPTH(4), .LG_REQ_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .ic_mem_addr  (ic_mem_addr),
        .ic_mem_xid   (ic_mem_xid),
        .ic_mem_re    (ic_mem_re),
        .mem_ic_ready (mem_ic_ready),
        .mem_ic_valid (mem_ic_valid),
        .mem_ic_xid   (mem_ic_xid),
        .mem_ic_data  (mem_ic_data),
        .dram_req     (dram_req),
        .dram_addr    (dram_addr),
        .dram_gnt     (dram_gnt),
        .dram_rvalid  (dram_rvalid),
        .dram_rdata   (dram_rdata),
        .resp_err     (resp_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [22:0]  addr;
        logic [1:0]   xid;
        logic [31:0]  b0, b1, b2, b3;
        int           gap;        // idle cycles before each beat
        int           gnt_wait;   // cycles dram_req is held before gnt
        logic [127:0] exp;        // expected returned line
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [22:0] a, input logic [1:0] x);
        ic_mem_re   = 1'b1;
        ic_mem_addr = a;
        ic_mem_xid  = x;
        tick();
        ic_mem_re   = 1'b0;
    endtask

    // Serves the burst at the FIFO head: waits (bounded) for dram_req, holds
    // gnt off for gnt_wait cycles, grants, supplies four beats with gaps and
    // checks the single-cycle line return. req_lat < 0 skips latency check.
    task automatic serve(input logic [22:0] a, input logic [1:0] x,
                         input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3,
                         input int gap, input int gnt_wait,
                         input logic [127:0] exp, input int req_lat);
        int waited;
        logic [31:0] beats[4];
        beats  = '{b0, b1, b2, b3};
        waited = 0;
        while (!dram_req && waited < 20) begin
            tick();
            waited++;
        end
        check("dram_req_seen", dram_req, 1'b1);
        if (!dram_req) return;
        if (req_lat >= 0) check("req_latency", waited, req_lat);
        check("dram_addr", dram_addr, a);
        for (int i = 0; i < gnt_wait; i++) begin
            tick();
            check("req_hold", dram_req, 1'b1);
            check("addr_hold", dram_addr, a);
        end
        dram_gnt = 1'b1;
        tick();
        dram_gnt = 1'b0;
        check("req_drop_after_gnt", dram_req, 1'b0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) tick();
            check("no_early_valid", mem_ic_valid, 1'b0);
            dram_rvalid = 1'b1;
            dram_rdata  = beats[i];
            tick();
            dram_rvalid = 1'b0;
            dram_rdata  = '0;
        end
        check("resp_valid", mem_ic_valid, 1'b1);
        check("resp_xid", mem_ic_xid, x);
        check("resp_data", mem_ic_data, exp);
        tick();
        check("valid_one_cycle", mem_ic_valid, 1'b0);
        check("data_held", mem_ic_data, exp);
        check("xid_held", mem_ic_xid, x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{addr: 23'h000123, xid: 2'd2,
                    b0: 32'h11111111, b1: 32'h22222222, b2: 32'h33333333, b3: 32'h44444444,
                    gap: 0, gnt_wait: 0,
                    exp: 128'h44444444_33333333_22222222_11111111};
        vecs[1] = '{addr: 23'h7FFFFF, xid: 2'd3,
                    b0: 32'hDEADBEEF, b1: 32'h01234567, b2: 32'h89ABCDEF, b3: 32'hFFFFFFFF,
                    gap: 0, gnt_wait: 10,
                    exp: 128'hFFFFFFFF_89ABCDEF_01234567_DEADBEEF};
        vecs[2] = '{addr: 23'h000000, xid: 2'd0,
                    b0: 32'hA0A0A0A0, b1: 32'h0B0B0B0B, b2: 32'hC0C0C0C0, b3: 32'h0D0D0D0D,
                    gap: 3, gnt_wait: 2,
                    exp: 128'h0D0D0D0D_C0C0C0C0_0B0B0B0B_A0A0A0A0};
        vecs[3] = '{addr: 23'h2AAAAA, xid: 2'd1,
                    b0: 32'h00000001, b1: 32'h00000002, b2: 32'h00000004, b3: 32'h00000008,
                    gap: 1, gnt_wait: 0,
                    exp: 128'h00000008_00000004_00000002_00000001};

        // Reset state
        tick();
        tick();
        check("ready_in_reset", mem_ic_ready, 1'b0);
        rst = 1'b0;
        tick();
        check("rst_ready", mem_ic_ready, 1'b1);
        check("rst_valid", mem_ic_valid, 1'b0);
        check("rst_xid", mem_ic_xid, 2'd0);
        check("rst_data", mem_ic_data, 128'd0);
        check("rst_dram_req", dram_req, 1'b0);
        check("rst_dram_addr", dram_addr, 23'd0);
        check("rst_resp_err", resp_err, 1'b0);

        // Single-line transactions from an idle block
        for (int v = 0; v < 4; v++) begin
            push(vecs[v].addr, vecs[v].xid);
            serve(vecs[v].addr, vecs[v].xid, vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3,
                  vecs[v].gap, vecs[v].gnt_wait, vecs[v].exp, 1);
        end

        // FIFO full: five pushes with gnt low, fifth is dropped
        for (int i = 0; i < 5; i++) begin
            check("ready_before_push", mem_ic_ready, (i < 4) ? 1'b1 : 1'b0);
            ic_mem_re   = 1'b1;
            ic_mem_addr = 23'h000100 + 23'(i);
            ic_mem_xid  = 2'(i);
            tick();
        end
        ic_mem_re = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("full_no_pop", mem_ic_ready, 1'b0);
        check("full_head_addr", dram_addr, 23'h000100);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] b0, b1, b2, b3;
            b0 = 32'hA0000000 | 32'(i);
            b1 = 32'hB0000000 | 32'(i);
            b2 = 32'hC0000000 | 32'(i);
            b3 = 32'hD0000000 | 32'(i);
            serve(23'h000100 + 23'(i), 2'(i), b0, b1, b2, b3, 0, 0, {b3, b2, b1, b0}, -1);
        end
        tick();
        tick();
        check("dropped_not_served", dram_req, 1'b0);
        check("ready_after_drain", mem_ic_ready, 1'b1);
        check("no_err_so_far", resp_err, 1'b0);

        // Reset after beat 1 of a burst
        begin
            int waited;
            push(23'h055555, 2'd3);
            waited = 0;
            while (!dram_req && waited < 20) begin
                tick();
                waited++;
            end
            check("mid_rst_req_seen", dram_req, 1'b1);
            dram_gnt = 1'b1;
            tick();
            dram_gnt = 1'b0;
            for (int i = 0; i < 2; i++) begin
                dram_rvalid = 1'b1;
                dram_rdata  = 32'hEEEE0000 | 32'(i);
                tick();
            end
            dram_rvalid = 1'b0;
            rst = 1'b1;
            tick();
            check("mid_rst_ready_low", mem_ic_ready, 1'b0);
            check("mid_rst_valid", mem_ic_valid, 1'b0);
            rst = 1'b0;
            tick();
            check("post_rst_ready", mem_ic_ready, 1'b1);
            check("post_rst_xid", mem_ic_xid, 2'd0);
            check("post_rst_data", mem_ic_data, 128'd0);
            check("post_rst_dram_addr", dram_addr, 23'd0);
            check("post_rst_err", resp_err, 1'b0);
            for (int i = 0; i < 4; i++) begin
                tick();
                check("post_rst_no_valid", mem_ic_valid, 1'b0);
                check("post_rst_no_req", dram_req, 1'b0);
            end
            push(23'h012345, 2'd1);
            serve(23'h012345, 2'd1, 32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 32'h0000DDDD,
                  0, 0, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, 1);
        end

        // Stray beat in IDLE sets the sticky error flag
        dram_rvalid = 1'b1;
        dram_rdata  = 32'hBADBAD00;
        tick();
        dram_rvalid = 1'b0;
        check("err_set", resp_err, 1'b1);
        check("err_no_valid", mem_ic_valid, 1'b0);
        tick();
        check("err_no_valid_later", mem_ic_valid, 1'b0);
        check("err_no_req", dram_req, 1'b0);
        push(vecs[0].addr, vecs[0].xid);
        serve(vecs[0].addr, vecs[0].xid, vecs[0].b0, vecs[0].b1, vecs[0].b2, vecs[0].b3,
              0, 0, vecs[0].exp, 1);
        check("err_sticky", resp_err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("err_cleared_by_rst", resp_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
